// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32 in-order pipeline: widths, the x0 index,
// and the state encoding of the operand issue stage.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  // RUN: normal issue. BUBBLE: one bubble was inserted for a load-use
  // dependency, and the load result now arrives on the MEM forward path.
  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } issue_state_e;

endpackage

// File: rtl/operand_fwd_mux.sv
// Per-operand forwarding select. Sources in priority order: the EX-stage ALU
// result, then the MEM-stage result, then the register file. Reads of x0
// always produce zero, whatever the sources say. The hit flag reports that
// the operand is really read and came from a forward path.
module operand_fwd_mux
  import riscv_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic                  use_rs,
  input  logic                  ex_valid,
  input  logic                  ex_rd_wen,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [W-1:0]          ex_data,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [W-1:0]          mem_data,
  input  logic [W-1:0]          rf_data,
  output logic [W-1:0]          data,
  output logic                  hit
);

  logic is_zero;
  logic ex_hit;
  logic mem_hit;

  assign is_zero = (rs == ZERO_REG);

  // A load in EX has no result yet, so it can never be an EX forward source;
  // that case is covered by the load-use bubble instead.
  assign ex_hit  = ex_valid & ex_rd_wen & ~ex_is_load & (ex_rd == rs) & ~is_zero;
  assign mem_hit = mem_valid & (mem_rd == rs) & ~is_zero;

  assign hit = use_rs & (ex_hit | mem_hit);

  // Priority select of the operand value, x0 forced to zero.
  always_comb begin
    data = rf_data;
    if (is_zero) begin
      data = '0;
    end else if (ex_hit) begin
      data = ex_data;
    end else if (mem_hit) begin
      data = mem_data;
    end
  end

endmodule

// File: rtl/operand_issue_stage.sv
// ID->EX issue stage of the in-order RV32 pipeline. Drives the register-file
// read ports from the decoded instruction, resolves both operands through the
// EX/MEM forward paths, inserts one bubble on a load-use dependency, and
// registers the result into the ID/EX register under valid/ready flow control.
module operand_issue_stage
  import riscv_pkg::*;
#(
  parameter int XLEN        = riscv_pkg::XLEN,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_valid,
  output logic                   id_ready,
  input  logic [XLEN-1:0]        id_pc,
  input  logic [REG_ADDR_W-1:0]  id_rs1,
  input  logic [REG_ADDR_W-1:0]  id_rs2,
  input  logic                   id_use_rs1,
  input  logic                   id_use_rs2,
  input  logic [REG_ADDR_W-1:0]  id_rd,
  input  logic                   id_rd_wen,
  input  logic                   id_is_load,
  input  logic [XLEN-1:0]        id_imm,
  output logic [REG_ADDR_W-1:0]  rf_raddr1,
  output logic [REG_ADDR_W-1:0]  rf_raddr2,
  input  logic [XLEN-1:0]        rf_rdata1,
  input  logic [XLEN-1:0]        rf_rdata2,
  input  logic                   mem_fwd_valid,
  input  logic [REG_ADDR_W-1:0]  mem_fwd_rd,
  input  logic [XLEN-1:0]        mem_fwd_data,
  input  logic [XLEN-1:0]        ex_result,
  input  logic                   flush,
  output logic                   ex_valid,
  input  logic                   ex_ready,
  output logic [XLEN-1:0]        ex_pc,
  output logic [XLEN-1:0]        ex_imm,
  output logic [XLEN-1:0]        ex_op1,
  output logic [XLEN-1:0]        ex_op2,
  output logic [REG_ADDR_W-1:0]  ex_rd,
  output logic                   ex_rd_wen,
  output logic                   ex_is_load,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  // ID/EX pipeline register
  logic                   ex_valid_reg;
  logic [XLEN-1:0]        ex_pc_reg;
  logic [XLEN-1:0]        ex_imm_reg;
  logic [XLEN-1:0]        ex_op1_reg;
  logic [XLEN-1:0]        ex_op2_reg;
  logic [REG_ADDR_W-1:0]  ex_rd_reg;
  logic                   ex_rd_wen_reg;
  logic                   ex_is_load_reg;
  logic [STALL_CNT_W-1:0] stall_cnt_reg;

  issue_state_e state_reg;
  issue_state_e state_next;

  logic adv;
  logic hz;
  logic load_instr;
  logic load_bubble;
  logic stall_inc;

  // Per-operand views so both forwarding muxes come from one generate loop
  logic [REG_ADDR_W-1:0] src_rs  [2];
  logic                  src_use [2];
  logic [XLEN-1:0]       src_rf  [2];
  logic [XLEN-1:0]       op_res  [2];
  logic                  op_hit  [2];

  // The per-operand hit flags are kept for debug visibility only.
  logic unused_hits;

  assign rf_raddr1 = id_rs1;
  assign rf_raddr2 = id_rs2;

  assign src_rs[0]  = id_rs1;
  assign src_rs[1]  = id_rs2;
  assign src_use[0] = id_use_rs1;
  assign src_use[1] = id_use_rs2;
  assign src_rf[0]  = rf_rdata1;
  assign src_rf[1]  = rf_rdata2;

  assign unused_hits = op_hit[0] | op_hit[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      operand_fwd_mux #(
        .W(XLEN)
      ) u_fwd_mux (
        .rs        (src_rs[gi]),
        .use_rs    (src_use[gi]),
        .ex_valid  (ex_valid_reg),
        .ex_rd_wen (ex_rd_wen_reg),
        .ex_is_load(ex_is_load_reg),
        .ex_rd     (ex_rd_reg),
        .ex_data   (ex_result),
        .mem_valid (mem_fwd_valid),
        .mem_rd    (mem_fwd_rd),
        .mem_data  (mem_fwd_data),
        .rf_data   (src_rf[gi]),
        .data      (op_res[gi]),
        .hit       (op_hit[gi])
      );
    end
  endgenerate

  // The ID/EX register can take new contents when empty or being drained.
  assign adv = ~ex_valid_reg | ex_ready;

  // A load in EX whose destination is read by the instruction in ID cannot be
  // forwarded in time; its data only shows up once the load reaches MEM.
  assign hz = ex_valid_reg & ex_is_load_reg & ex_rd_wen_reg & (ex_rd_reg != ZERO_REG) &
              ((id_use_rs1 & (id_rs1 == ex_rd_reg)) | (id_use_rs2 & (id_rs2 == ex_rd_reg)));

  // During a flush the upstream instruction is acknowledged so it is dropped.
  assign id_ready = flush | (adv & ~(id_valid & hz));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: a load-use hazard diverts to BUBBLE for one issue slot.
  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = RUN;
    end else begin
      case (state_reg)
        RUN:     if (adv & id_valid & hz) state_next = BUBBLE;
        BUBBLE:  if (adv) state_next = RUN;
        default: state_next = RUN;
      endcase
    end
  end

  // Output logic: decide whether the ID/EX register loads an instruction,
  // loads a bubble, or holds, and whether a stall is being counted.
  always_comb begin
    load_instr  = 1'b0;
    load_bubble = 1'b0;
    stall_inc   = 1'b0;
    if (flush) begin
      load_bubble = 1'b1;
    end else if (adv) begin
      case (state_reg)
        RUN: begin
          if (id_valid & hz) begin
            load_bubble = 1'b1;
            stall_inc   = 1'b1;
          end else if (id_valid) begin
            load_instr = 1'b1;
          end else begin
            load_bubble = 1'b1;
          end
        end
        BUBBLE: begin
          if (id_valid) begin
            load_instr = 1'b1;
          end else begin
            load_bubble = 1'b1;
          end
        end
        default: load_bubble = 1'b1;
      endcase
    end
  end

  // ID/EX valid bit: set on an accepted instruction, cleared by a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid_reg <= 1'b0;
    end else if (load_instr) begin
      ex_valid_reg <= 1'b1;
    end else if (load_bubble) begin
      ex_valid_reg <= 1'b0;
    end
  end

  // ID/EX payload: operands are captured only at accept and then held, so a
  // stalled instruction is never re-forwarded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_pc_reg      <= '0;
      ex_imm_reg     <= '0;
      ex_op1_reg     <= '0;
      ex_op2_reg     <= '0;
      ex_rd_reg      <= '0;
      ex_rd_wen_reg  <= 1'b0;
      ex_is_load_reg <= 1'b0;
    end else if (load_instr) begin
      ex_pc_reg      <= id_pc;
      ex_imm_reg     <= id_imm;
      ex_op1_reg     <= op_res[0];
      ex_op2_reg     <= op_res[1];
      ex_rd_reg      <= id_rd;
      ex_rd_wen_reg  <= id_rd_wen;
      ex_is_load_reg <= id_is_load;
    end
  end

  // Saturating count of load-use bubbles; only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_reg <= '0;
    end else if (stall_inc && (stall_cnt_reg != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_reg <= stall_cnt_reg + STALL_CNT_W'(1);
    end
  end

  assign ex_valid   = ex_valid_reg;
  assign ex_pc      = ex_pc_reg;
  assign ex_imm     = ex_imm_reg;
  assign ex_op1     = ex_op1_reg;
  assign ex_op2     = ex_op2_reg;
  assign ex_rd      = ex_rd_reg;
  assign ex_rd_wen  = ex_rd_wen_reg;
  assign ex_is_load = ex_is_load_reg;
  assign stall_cnt  = stall_cnt_reg;

endmodule

// File: tb/tb_operand_issue_stage.sv
// Directed bench for operand_issue_stage: reset, forwarding priority,
// load-use bubbles, backpressure, flush, counter saturation, async reset.
module tb_operand_issue_stage;
  import riscv_pkg::*;

  localparam int W   = 32;
  localparam int SCW = 2;

  logic           clk;
  logic           reset;
  logic           id_valid;
  logic           id_ready;
  logic [W-1:0]   id_pc;
  logic [4:0]     id_rs1;
  logic [4:0]     id_rs2;
  logic           id_use_rs1;
  logic           id_use_rs2;
  logic [4:0]     id_rd;
  logic           id_rd_wen;
  logic           id_is_load;
  logic [W-1:0]   id_imm;
  logic [4:0]     rf_raddr1;
  logic [4:0]     rf_raddr2;
  logic [W-1:0]   rf_rdata1;
  logic [W-1:0]   rf_rdata2;
  logic           mem_fwd_valid;
  logic [4:0]     mem_fwd_rd;
  logic [W-1:0]   mem_fwd_data;
  logic [W-1:0]   ex_result;
  logic           flush;
  logic           ex_valid;
  logic           ex_ready;
  logic [W-1:0]   ex_pc;
  logic [W-1:0]   ex_imm;
  logic [W-1:0]   ex_op1;
  logic [W-1:0]   ex_op2;
  logic [4:0]     ex_rd;
  logic           ex_rd_wen;
  logic           ex_is_load;
  logic [SCW-1:0] stall_cnt;

  int tests_run;
  int tests_failed;

  operand_issue_stage #(
    .XLEN(W),
    .STALL_CNT_W(SCW)
  ) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_rd_wen(id_rd_wen), .id_is_load(id_is_load), .id_imm(id_imm),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .mem_fwd_valid(mem_fwd_valid), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .ex_result(ex_result), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_rd(ex_rd), .ex_rd_wen(ex_rd_wen),
    .ex_is_load(ex_is_load), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_pc = '0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_rd = '0; id_rd_wen = 0; id_is_load = 0; id_imm = '0;
    rf_rdata1 = '0; rf_rdata2 = '0; mem_fwd_valid = 0; mem_fwd_rd = '0; mem_fwd_data = '0;
    ex_result = '0; flush = 0; ex_ready = 1;
  endtask

  task automatic present(input logic [W-1:0] pc, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                         input logic wen, input logic ld,
                         input logic [W-1:0] rf1, input logic [W-1:0] rf2);
    id_valid = 1; id_pc = pc; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd; id_rd_wen = wen; id_is_load = ld; id_imm = pc ^ 32'h0000_FFFF;
    rf_rdata1 = rf1; rf_rdata2 = rf2;
  endtask

  task automatic test_reset();
    reset = 0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if (ex_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_ex_valid: got %0b expected 0", ex_valid); end
    tests_run++; if (ex_op1 !== 32'h0) begin tests_failed++; $display("FAIL reset_ex_op1: got %h expected 0", ex_op1); end
    tests_run++; if (ex_pc !== 32'h0) begin tests_failed++; $display("FAIL reset_ex_pc: got %h expected 0", ex_pc); end
    tests_run++; if (stall_cnt !== 2'd0) begin tests_failed++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
    tests_run++; if (dut.state_reg !== RUN) begin tests_failed++; $display("FAIL reset_state: got %0d expected RUN", dut.state_reg); end
    reset = 1;
    present(32'h100, 5'd1, 1, 5'd2, 1, 5'd4, 1, 0, 32'h1111, 32'h2222);
    #1;
    tests_run++; if (id_ready !== 1'b1) begin tests_failed++; $display("FAIL first_id_ready: got %0b expected 1", id_ready); end
    tests_run++; if (rf_raddr2 !== 5'd2) begin tests_failed++; $display("FAIL rf_raddr2: got %0d expected 2", rf_raddr2); end
    tick();
    tests_run++; if (ex_valid !== 1'b1) begin tests_failed++; $display("FAIL first_ex_valid: got %0b expected 1", ex_valid); end
    tests_run++; if (ex_pc !== 32'h100) begin tests_failed++; $display("FAIL first_ex_pc: got %h expected 100", ex_pc); end
    tests_run++; if (ex_imm !== 32'h0000_FEFF) begin tests_failed++; $display("FAIL first_ex_imm: got %h expected 0000feff", ex_imm); end
    tests_run++; if (ex_op1 !== 32'h1111 || ex_op2 !== 32'h2222) begin tests_failed++; $display("FAIL first_ops: got %h/%h expected 1111/2222", ex_op1, ex_op2); end
    tests_run++; if (ex_rd !== 5'd4 || ex_rd_wen !== 1'b1) begin tests_failed++; $display("FAIL first_rd: got %0d/%0b expected 4/1", ex_rd, ex_rd_wen); end
    id_valid = 0;
    tick();
    tests_run++; if (ex_valid !== 1'b0) begin tests_failed++; $display("FAIL idle_bubble: got %0b expected 0", ex_valid); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_ex_forward();
    present(32'h140, 5'd0, 0, 5'd0, 0, 5'd5, 1, 0, 32'h0, 32'h0);
    tick();
    present(32'h144, 5'd5, 1, 5'd0, 0, 5'd0, 0, 0, 32'h11, 32'h0);
    ex_result = 32'hDEAD;
    tick();
    tests_run++; if (ex_op1 !== 32'hDEAD) begin tests_failed++; $display("FAIL ex_fwd_op1: got %h expected dead", ex_op1); end
    present(32'h140, 5'd0, 0, 5'd0, 0, 5'd5, 1, 0, 32'h0, 32'h0);
    tick();
    present(32'h148, 5'd0, 1, 5'd0, 0, 5'd0, 0, 0, 32'h11, 32'h0);
    mem_fwd_valid = 1; mem_fwd_rd = 5'd0; mem_fwd_data = 32'h77;
    tick();
    tests_run++; if (ex_op1 !== 32'h0) begin tests_failed++; $display("FAIL x0_op1: got %h expected 0", ex_op1); end
    mem_fwd_valid = 0;
    $display("[TB] test_ex_forward done");
  endtask

  task automatic test_priority();
    present(32'h180, 5'd0, 0, 5'd0, 0, 5'd7, 1, 0, 32'h0, 32'h0);
    tick();
    present(32'h184, 5'd0, 0, 5'd7, 1, 5'd0, 0, 0, 32'h0, 32'hC);
    ex_result = 32'hA; mem_fwd_valid = 1; mem_fwd_rd = 5'd7; mem_fwd_data = 32'hB;
    tick();
    tests_run++; if (ex_op2 !== 32'hA) begin tests_failed++; $display("FAIL prio_ex: got %h expected a", ex_op2); end
    id_valid = 0;
    tick();
    id_valid = 1;
    tick();
    tests_run++; if (ex_op2 !== 32'hB) begin tests_failed++; $display("FAIL prio_mem: got %h expected b", ex_op2); end
    id_valid = 0;
    tick();
    mem_fwd_valid = 0; id_valid = 1;
    tick();
    tests_run++; if (ex_op2 !== 32'hC) begin tests_failed++; $display("FAIL prio_rf: got %h expected c", ex_op2); end
    $display("[TB] test_priority done");
  endtask

  task automatic test_load_use();
    present(32'h1F0, 5'd0, 0, 5'd0, 0, 5'd3, 1, 1, 32'h0, 32'h0);
    tick();
    present(32'h200, 5'd1, 1, 5'd3, 1, 5'd8, 1, 0, 32'h1, 32'h99);
    #1;
    tests_run++; if (id_ready !== 1'b0) begin tests_failed++; $display("FAIL lu_id_ready: got %0b expected 0", id_ready); end
    tick();
    tests_run++; if (ex_valid !== 1'b0) begin tests_failed++; $display("FAIL lu_bubble: got %0b expected 0", ex_valid); end
    tests_run++; if (stall_cnt !== 2'd1) begin tests_failed++; $display("FAIL lu_stall_cnt: got %0d expected 1", stall_cnt); end
    tests_run++; if (dut.state_reg !== BUBBLE) begin tests_failed++; $display("FAIL lu_state: got %0d expected BUBBLE", dut.state_reg); end
    tests_run++; if (ex_pc !== 32'h1F0) begin tests_failed++; $display("FAIL lu_hold_pc: got %h expected 1f0", ex_pc); end
    mem_fwd_valid = 1; mem_fwd_rd = 5'd3; mem_fwd_data = 32'h55;
    #1;
    tests_run++; if (id_ready !== 1'b1) begin tests_failed++; $display("FAIL lu_retry_ready: got %0b expected 1", id_ready); end
    tick();
    tests_run++; if (ex_valid !== 1'b1 || ex_pc !== 32'h200) begin tests_failed++; $display("FAIL lu_accept: got %0b/%h expected 1/200", ex_valid, ex_pc); end
    tests_run++; if (ex_op2 !== 32'h55 || ex_op1 !== 32'h1) begin tests_failed++; $display("FAIL lu_ops: got %h/%h expected 1/55", ex_op1, ex_op2); end
    tests_run++; if (dut.state_reg !== RUN) begin tests_failed++; $display("FAIL lu_state_run: got %0d expected RUN", dut.state_reg); end
    mem_fwd_valid = 0;
    present(32'h1F0, 5'd0, 0, 5'd0, 0, 5'd3, 1, 1, 32'h0, 32'h0);
    tick();
    present(32'h200, 5'd1, 1, 5'd3, 0, 5'd8, 1, 0, 32'h1, 32'h99);
    #1;
    tests_run++; if (id_ready !== 1'b1) begin tests_failed++; $display("FAIL nouse_ready: got %0b expected 1", id_ready); end
    tick();
    tests_run++; if (ex_valid !== 1'b1 || stall_cnt !== 2'd1) begin tests_failed++; $display("FAIL nouse_accept: got %0b/%0d expected 1/1", ex_valid, stall_cnt); end
    $display("[TB] test_load_use done");
  endtask

  task automatic test_backpressure_flush();
    present(32'h300, 5'd2, 1, 5'd0, 0, 5'd9, 1, 0, 32'h2222, 32'h0);
    tick();
    present(32'h400, 5'd2, 1, 5'd0, 0, 5'd10, 1, 0, 32'h9999, 32'h0);
    ex_ready = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests_run++; if (id_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_id_ready[%0d]: got %0b expected 0", i, id_ready); end
      tick();
      tests_run++; if (ex_valid !== 1'b1 || ex_pc !== 32'h300 || ex_op1 !== 32'h2222) begin
        tests_failed++; $display("FAIL bp_hold[%0d]: got %0b/%h/%h expected 1/300/2222", i, ex_valid, ex_pc, ex_op1);
      end
    end
    flush = 1;
    #1;
    tests_run++; if (id_ready !== 1'b1) begin tests_failed++; $display("FAIL flush_id_ready: got %0b expected 1", id_ready); end
    tick();
    tests_run++; if (ex_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_ex_valid: got %0b expected 0", ex_valid); end
    flush = 0; ex_ready = 1;
    $display("[TB] test_backpressure_flush done");
  endtask

  task automatic test_flush_hazard();
    present(32'h500, 5'd0, 0, 5'd0, 0, 5'd3, 1, 1, 32'h0, 32'h0);
    tick();
    present(32'h504, 5'd0, 0, 5'd3, 1, 5'd8, 1, 0, 32'h0, 32'h0);
    flush = 1;
    #1;
    tests_run++; if (id_ready !== 1'b1) begin tests_failed++; $display("FAIL flhz_ready: got %0b expected 1", id_ready); end
    tick();
    tests_run++; if (ex_valid !== 1'b0 || stall_cnt !== 2'd1) begin tests_failed++; $display("FAIL flhz_state: got %0b/%0d expected 0/1", ex_valid, stall_cnt); end
    tests_run++; if (dut.state_reg !== RUN) begin tests_failed++; $display("FAIL flhz_fsm: got %0d expected RUN", dut.state_reg); end
    flush = 0;
    $display("[TB] test_flush_hazard done");
  endtask

  task automatic test_saturation();
    int exp_stall;
    exp_stall = 1;
    for (int i = 0; i < 6; i++) begin
      present(32'h600, 5'd0, 0, 5'd0, 0, 5'd3, 1, 1, 32'h0, 32'h0);
      tick();
      present(32'h604, 5'd3, 1, 5'd0, 0, 5'd8, 1, 0, 32'h0, 32'h0);
      tick();
      exp_stall = (exp_stall == 3) ? 3 : exp_stall + 1;
      tests_run++; if (stall_cnt !== exp_stall[1:0]) begin tests_failed++; $display("FAIL sat_cnt[%0d]: got %0d expected %0d", i, stall_cnt, exp_stall); end
    end
    $display("[TB] test_saturation done");
  endtask

  task automatic test_async_reset();
    present(32'h700, 5'd0, 0, 5'd0, 0, 5'd1, 1, 0, 32'h0, 32'h0);
    tick();
    tests_run++; if (ex_valid !== 1'b1) begin tests_failed++; $display("FAIL ar_pre_valid: got %0b expected 1", ex_valid); end
    #2;
    reset = 0;
    #1;
    tests_run++; if (ex_valid !== 1'b0 || ex_pc !== 32'h0) begin tests_failed++; $display("FAIL ar_clear: got %0b/%h expected 0/0", ex_valid, ex_pc); end
    tests_run++; if (stall_cnt !== 2'd0) begin tests_failed++; $display("FAIL ar_stall: got %0d expected 0", stall_cnt); end
    tick();
    reset = 1;
    idle_inputs();
    $display("[TB] test_async_reset done");
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_ex_forward();
    test_priority();
    test_load_use();
    test_backpressure_flush();
    test_flush_hazard();
    test_saturation();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
